muldiv_seq: RTL

- Multi-cycle sequencer for the RV64M opcodes (MUL..REMUW). It replaces the single-cycle `*`, `/` and `%` paths of the combinational ALU with an iterative shift-add multiplier and a restoring divider, both under one FSM.
- Decode steers M-ext instructions here through a valid/ready handshake. The result returns to writeback through a second valid/ready handshake.
- Opcode encoding is the same 8-bit ALU instruction code used by the ALU.

---
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV64M sequencer: iterative shift-add multiplier and restoring divider
// under one FSM, with valid/ready handshakes on both the request and result sides.
module muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and payload is held while valid && !ready.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [7:0] OP_MUL    = 8'd10;
  localparam logic [7:0] OP_MULH   = 8'd11;
  localparam logic [7:0] OP_MULHSU = 8'd12;
  localparam logic [7:0] OP_MULHU  = 8'd13;
  localparam logic [7:0] OP_DIV    = 8'd14;
  localparam logic [7:0] OP_DIVU   = 8'd15;
  localparam logic [7:0] OP_REM    = 8'd16;
  localparam logic [7:0] OP_REMU   = 8'd17;
  localparam logic [7:0] OP_MULW   = 8'd38;
  localparam logic [7:0] OP_DIVW   = 8'd39;
  localparam logic [7:0] OP_DIVUW  = 8'd40;
  localparam logic [7:0] OP_REMW   = 8'd41;
  localparam logic [7:0] OP_REMUW  = 8'd42;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              op_mul_q, op_w_q, sel_hi_q, sel_rem_q, neg_res_q, neg_rem_q;
  logic [XLEN-1:0]   b_q, rem_q, quo_q;
  logic [2*XLEN-1:0] prod_q;

  // Request decode
  logic d_known, d_mul, d_div, d_rem, d_w, d_sa, d_sb, d_hi;

  always_comb begin
    d_known = 1'b1;
    d_mul   = 1'b0;
    d_div   = 1'b0;
    d_rem   = 1'b0;
    d_w     = 1'b0;
    d_sa    = 1'b0;
    d_sb    = 1'b0;
    d_hi    = 1'b0;
    case (instruction)
      OP_MUL:    begin d_mul = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
      OP_MULH:   begin d_mul = 1'b1; d_hi = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
      OP_MULHSU: begin d_mul = 1'b1; d_hi = 1'b1; d_sa = 1'b1; end
      OP_MULHU:  begin d_mul = 1'b1; d_hi = 1'b1; end
      OP_DIV:    begin d_div = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
      OP_DIVU:   begin d_div = 1'b1; end
      OP_REM:    begin d_div = 1'b1; d_rem = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
      OP_REMU:   begin d_div = 1'b1; d_rem = 1'b1; end
      OP_MULW:   begin d_mul = 1'b1; d_w = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
      OP_DIVW:   begin d_div = 1'b1; d_w = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
      OP_DIVUW:  begin d_div = 1'b1; d_w = 1'b1; end
      OP_REMW:   begin d_div = 1'b1; d_rem = 1'b1; d_w = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
      OP_REMUW:  begin d_div = 1'b1; d_rem = 1'b1; d_w = 1'b1; end
      default:   d_known = 1'b0;
    endcase
  end

  // Operand extension, magnitudes and special-case detection
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_raw, spec_res;
  logic            a_neg, b_neg, div_zero, div_ovf, special, accept;

  always_comb begin
    a_ext = d_w ? (d_sa ? {{32{rs1[31]}}, rs1[31:0]} : {32'b0, rs1[31:0]}) : rs1;
    b_ext = d_w ? (d_sb ? {{32{rs2[31]}}, rs2[31:0]} : {32'b0, rs2[31:0]}) : rs2;
    a_neg = d_sa & a_ext[XLEN-1];
    b_neg = d_sb & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    div_zero = d_div & (b_ext == '0);
    div_ovf  = d_div & d_sa & d_sb & ~div_zero &
               (d_w ? (rs1[31:0] == 32'h8000_0000 && rs2[31:0] == 32'hFFFF_FFFF)
                    : (rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1));
    special  = ~d_known | div_zero | div_ovf;
    spec_raw = '0;
    if (d_known && div_zero)     spec_raw = d_rem ? a_ext : '1;
    else if (d_known && div_ovf) spec_raw = d_rem ? '0 : a_ext;
    spec_res = d_w ? {{32{spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
    accept   = in_valid & in_ready & ~flush;
  end

  // One iteration step for each engine
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] prod_next;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    prod_next = {mul_sum, prod_q[XLEN-1:1]};
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    rem_diff  = rem_sh - {1'b0, b_q};
  end

  // Sign fix-up and output select; W products sit 32 bits high after 32 steps
  logic [2*XLEN-1:0] prod_adj, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_raw, fix_res;

  always_comb begin
    prod_adj = op_w_q ? {32'b0, prod_q[2*XLEN-1:32]} : prod_q;
    prod_s   = neg_res_q ? -prod_adj : prod_adj;
    quo_s    = neg_res_q ? -quo_q : quo_q;
    rem_s    = neg_rem_q ? -rem_q : rem_q;
    if (op_mul_q) fix_raw = sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    else          fix_raw = sel_rem_q ? rem_s : quo_s;
    fix_res = op_w_q ? {{32{fix_raw[31]}}, fix_raw[31:0]} : fix_raw;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (flush) state_d = IDLE;
            else if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      cnt_q     <= '0;
      op_mul_q  <= 1'b0;
      op_w_q    <= 1'b0;
      sel_hi_q  <= 1'b0;
      sel_rem_q <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      prod_q    <= '0;
    end else if (accept) begin
      op_mul_q  <= d_mul;
      op_w_q    <= d_w;
      sel_hi_q  <= d_hi;
      sel_rem_q <= d_rem;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      b_q       <= b_mag;
      rem_q     <= '0;
      // W dividends start at the top so 32 left shifts consume them exactly
      quo_q     <= d_w ? {a_mag[31:0], 32'b0} : a_mag;
      prod_q    <= {{XLEN{1'b0}}, a_mag};
      if (special) begin
        result <= spec_res;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= d_w ? CNT_W'(31) : CNT_W'(XLEN-1);
      end
    end else if (state_q == CALC && !flush) begin
      cnt_q  <= cnt_q - 1'b1;
      prod_q <= prod_next;
      if (rem_diff[XLEN]) begin
        rem_q <= rem_sh[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end else begin
        rem_q <= rem_diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end
    end else if (state_q == FIX && !flush) begin
      result <= fix_res;
    end
  end

endmodule
